// File: rtl/operand_regfile.sv
// Operand register file: one write port, two registered read ports
// with write-first bypass and an optional hardwired-zero r0.
module operand_regfile #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned AW      = 2,
    parameter bit          ZERO_R0 = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             ren,
    input  logic [AW-1:0]    raddr0,
    input  logic [AW-1:0]    raddr1,
    output logic [WIDTH-1:0] rdata0,
    output logic [WIDTH-1:0] rdata1,
    output logic             rvalid
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic             wr_in_range;
    logic             wr_is_r0;
    logic             wr_ok;
    logic [WIDTH-1:0] regs_q  [DEPTH];
    logic [AW-1:0]    raddr   [2];
    logic [WIDTH-1:0] rval    [2];
    logic [WIDTH-1:0] rdata_d [2];
    logic [WIDTH-1:0] rdata_q [2];
    logic             rvalid_d;
    logic             rvalid_q;

    assign wr_in_range = ({1'b0, waddr} < DEPTH_W);
    assign wr_is_r0    = ZERO_R0 && (waddr == '0);
    assign wr_ok       = we && wr_in_range && !wr_is_r0;

    assign raddr[0] = raddr0;
    assign raddr[1] = raddr1;

    for (genvar g = 0; g < DEPTH; g++) begin : g_reg
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                regs_q[g] <= '0;
            end else if (wr_ok && (waddr == AW'(g))) begin
                regs_q[g] <= wdata;
            end
        end
    end

    // Only accepted writes are bypassed, so a rejected write never leaks.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rval[p] = '0;
            if ({1'b0, raddr[p]} >= DEPTH_W) begin
                rval[p] = '0;
            end else if (ZERO_R0 && (raddr[p] == '0)) begin
                rval[p] = '0;
            end else if (wr_ok && (waddr == raddr[p])) begin
                rval[p] = wdata;
            end else begin
                for (int r = 0; r < DEPTH; r++) begin
                    if (raddr[p] == AW'(r)) begin
                        rval[p] = regs_q[r];
                    end
                end
            end
        end
    end

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rdata_d[p] = ren ? rval[p] : rdata_q[p];
        end
        rvalid_d = ren;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q[0] <= '0;
            rdata_q[1] <= '0;
            rvalid_q   <= 1'b0;
        end else begin
            rdata_q[0] <= rdata_d[0];
            rdata_q[1] <= rdata_d[1];
            rvalid_q   <= rvalid_d;
        end
    end

    assign rdata0 = rdata_q[0];
    assign rdata1 = rdata_q[1];
    assign rvalid = rvalid_q;

endmodule

// File: tb/tb_operand_regfile.sv
// Directed vector bench for operand_regfile in three configurations:
// default, ZERO_R0=0, and DEPTH=3.
module tb_operand_regfile;

    logic       clk;
    logic       rst;
    logic       we;
    logic [1:0] waddr;
    logic [7:0] wdata;
    logic       ren;
    logic [1:0] raddr0;
    logic [1:0] raddr1;

    logic [7:0] m_rd0, m_rd1, z_rd0, z_rd1, d_rd0, d_rd1;
    logic       m_rv, z_rv, d_rv;

    int n_cmp = 0;
    int n_err = 0;

    operand_regfile u_main (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .ren(ren), .raddr0(raddr0), .raddr1(raddr1),
        .rdata0(m_rd0), .rdata1(m_rd1), .rvalid(m_rv)
    );

    operand_regfile #(.ZERO_R0(1'b0)) u_z0 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .ren(ren), .raddr0(raddr0), .raddr1(raddr1),
        .rdata0(z_rd0), .rdata1(z_rd1), .rvalid(z_rv)
    );

    operand_regfile #(.DEPTH(3)) u_d3 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .ren(ren), .raddr0(raddr0), .raddr1(raddr1),
        .rdata0(d_rd0), .rdata1(d_rd1), .rvalid(d_rv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       we;
        logic [1:0] wa;
        logic [7:0] wd;
        logic       ren;
        logic [1:0] ra0;
        logic [1:0] ra1;
        logic [7:0] e0;
        logic [7:0] e1;
        logic       ev;
    } vec_t;

    function automatic vec_t mk(
        input logic w, input logic [1:0] wa, input logic [7:0] wd,
        input logic r, input logic [1:0] a0, input logic [1:0] a1,
        input logic [7:0] e0, input logic [7:0] e1, input logic ev);
        vec_t v;
        v.we = w; v.wa = wa; v.wd = wd;
        v.ren = r; v.ra0 = a0; v.ra1 = a1;
        v.e0 = e0; v.e1 = e1; v.ev = ev;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h want %02h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0b want %0b", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic [1:0] wa, input logic [7:0] wd,
                         input logic r, input logic [1:0] a0, input logic [1:0] a1);
        we = w; waddr = wa; wdata = wd;
        ren = r; raddr0 = a0; raddr1 = a1;
    endtask

    vec_t       vt [11];
    logic [7:0] mdl [4];
    logic [7:0] x0, x1;
    logic [1:0] sa0, sa1;

    function automatic logic [7:0] mval(input logic [1:0] a, input logic w,
                                        input logic [1:0] wa, input logic [7:0] wd);
        if (a == 2'd0) return 8'h00;
        if (w && wa == a) return wd;
        return mdl[a];
    endfunction

    initial begin
        vt[0]  = mk(1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 2'd3, 8'h00, 8'h00, 1'b1);
        vt[1]  = mk(1'b1, 2'd1, 8'hA5, 1'b0, 2'd0, 2'd0, 8'h00, 8'h00, 1'b0);
        vt[2]  = mk(1'b1, 2'd3, 8'h3C, 1'b0, 2'd0, 2'd0, 8'h00, 8'h00, 1'b0);
        vt[3]  = mk(1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 2'd3, 8'hA5, 8'h3C, 1'b1);
        vt[4]  = mk(1'b0, 2'd0, 8'h00, 1'b0, 2'd2, 2'd2, 8'hA5, 8'h3C, 1'b0);
        vt[5]  = mk(1'b1, 2'd2, 8'h11, 1'b0, 2'd0, 2'd0, 8'hA5, 8'h3C, 1'b0);
        vt[6]  = mk(1'b1, 2'd2, 8'h77, 1'b1, 2'd2, 2'd2, 8'h77, 8'h77, 1'b1);
        vt[7]  = mk(1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 2'd1, 8'h77, 8'hA5, 1'b1);
        vt[8]  = mk(1'b1, 2'd0, 8'hC3, 1'b1, 2'd0, 2'd0, 8'h00, 8'h00, 1'b1);
        vt[9]  = mk(1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 2'd2, 8'h00, 8'h77, 1'b1);
        vt[10] = mk(1'b1, 2'd1, 8'h5A, 1'b1, 2'd3, 2'd1, 8'h3C, 8'h5A, 1'b1);

        // Reset with we/ren active: both must be ignored.
        rst = 1'b1;
        drive(1'b1, 2'd1, 8'hEE, 1'b1, 2'd1, 2'd1);
        tick();
        tick();
        chk("rst_rd0", m_rd0, 8'h00);
        chk("rst_rd1", m_rd1, 8'h00);
        chk1("rst_rv", m_rv, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            drive(vt[i].we, vt[i].wa, vt[i].wd, vt[i].ren, vt[i].ra0, vt[i].ra1);
            tick();
            chk($sformatf("vec%0d_rd0", i), m_rd0, vt[i].e0);
            chk($sformatf("vec%0d_rd1", i), m_rd1, vt[i].e1);
            chk1($sformatf("vec%0d_rv", i), m_rv, vt[i].ev);
        end

        // Zero register: no bypass when hardwired, bypass when not.
        drive(1'b1, 2'd0, 8'hFF, 1'b1, 2'd0, 2'd0);
        tick();
        chk("zero_byp_main", m_rd0, 8'h00);
        chk("zero_byp_z0", z_rd0, 8'hFF);
        drive(1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 2'd2);
        tick();
        chk("zero_late_main", m_rd0, 8'h00);
        chk("zero_late_z0", z_rd0, 8'hFF);
        chk("zero_late_z0_r2", z_rd1, 8'h77);

        // Out-of-range write on DEPTH=3.
        drive(1'b1, 2'd2, 8'h66, 1'b0, 2'd0, 2'd0);
        tick();
        drive(1'b1, 2'd3, 8'h55, 1'b1, 2'd3, 2'd3);
        tick();
        chk("oor_byp_d3", d_rd0, 8'h00);
        chk("oor_byp_main", m_rd0, 8'h55);
        drive(1'b0, 2'd0, 8'h00, 1'b1, 2'd3, 2'd2);
        tick();
        chk("oor_rd3_d3", d_rd0, 8'h00);
        chk("oor_rd2_d3", d_rd1, 8'h66);
        chk("oor_rd3_main", m_rd0, 8'h55);
        drive(1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 2'd0);
        tick();
        chk("oor_rd1_d3", d_rd0, 8'h5A);
        chk("oor_rd0_d3", d_rd1, 8'h00);

        // Asynchronous reset between edges.
        drive(1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 2'd3);
        tick();
        chk("pre_arst_rd0", m_rd0, 8'h5A);
        chk("pre_arst_rd1", m_rd1, 8'h55);
        chk1("pre_arst_rv", m_rv, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("arst_rd0", m_rd0, 8'h00);
        chk("arst_rd1", m_rd1, 8'h00);
        chk1("arst_rv", m_rv, 1'b0);
        tick();
        chk1("arst_edge_rv", m_rv, 1'b0);
        rst = 1'b0;
        tick();
        chk("post_arst_rd0", m_rd0, 8'h00);
        chk("post_arst_rd1", m_rd1, 8'h00);
        chk1("post_arst_rv", m_rv, 1'b1);

        // Back-to-back streaming with writes on every cycle.
        for (int k = 0; k < 4; k++) mdl[k] = 8'h00;
        for (int i = 0; i < 8; i++) begin
            sa0 = 2'(i % 4);
            sa1 = 2'((i + 1) % 4);
            drive(1'b1, sa0, 8'(8'h10 + i), 1'b1, sa0, sa1);
            x0 = mval(sa0, 1'b1, sa0, 8'(8'h10 + i));
            x1 = mval(sa1, 1'b1, sa0, 8'(8'h10 + i));
            if (sa0 != 2'd0) mdl[sa0] = 8'(8'h10 + i);
            tick();
            chk($sformatf("strm%0d_rd0", i), m_rd0, x0);
            chk($sformatf("strm%0d_rd1", i), m_rd1, x1);
            chk1($sformatf("strm%0d_rv", i), m_rv, 1'b1);
        end
        drive(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 2'd0);
        tick();
        chk1("strm_end_rv", m_rv, 1'b0);
        chk("strm_end_hold0", m_rd0, x0);
        chk("strm_end_hold1", m_rd1, x1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
